// File: rtl/ibex_ex_multdiv_iter.sv
// Iterative multiply/divide unit for the EX stage. It retires StepBits bits per CALC cycle,
// uses a valid/ready request/response handshake, and supports early termination and kill.
module ibex_ex_multdiv_iter #(
    parameter int Width     = 32,
    parameter int StepBits  = 1,
    parameter bit EarlyTerm = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       op_i,
    input  logic             signed_i,
    input  logic [Width-1:0] operand_a_i,
    input  logic [Width-1:0] operand_b_i,
    input  logic             data_ind_timing_i,
    input  logic             kill_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [Width-1:0] result_o,
    output logic             busy_o
);
    localparam int N    = Width / StepBits;
    localparam int CntW = $clog2(N + 1);
    localparam logic [CntW-1:0] CntInit = CntW'(N);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULH = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;

    localparam logic [Width-1:0] MinNeg = {1'b1, {(Width-1){1'b0}}};

    logic [1:0]         state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic               dit_q, dit_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_a_q, neg_a_d;
    logic               div_zero_q, div_zero_d;
    logic               ovf_q, ovf_d;
    logic [Width-1:0]   a_q, a_d;
    logic [Width-1:0]   opb_q, opb_d;
    logic [2*Width-1:0] mcand_q, mcand_d;
    logic [2*Width-1:0] acc_q, acc_d;
    logic [Width-1:0]   dq_q, dq_d;
    logic [Width-1:0]   rem_q, rem_d;
    logic [Width-1:0]   result_q, result_d;

    logic               accept;
    logic               a_neg, b_neg, b_zero, ovf_in, bypass;
    logic [Width-1:0]   mag_a, mag_b;
    logic [2*Width-1:0] mul_acc;
    logic [Width-1:0]   mul_b_rest;
    logic [Width:0]     div_r;
    logic [Width-1:0]   div_q;
    logic [CntW-1:0]    cnt_dec;
    logic [2*Width-1:0] prod;
    logic [Width-1:0]   quo, remv, fin_res;
    logic               mul_early;

    assign req_ready_o  = (state_q == IDLE) & ~kill_i;
    assign resp_valid_o = (state_q == DONE);
    assign busy_o       = (state_q != IDLE);
    assign result_o     = result_q;

    assign accept  = req_valid_i & req_ready_o;
    assign a_neg   = signed_i & operand_a_i[Width-1];
    assign b_neg   = signed_i & operand_b_i[Width-1];
    assign mag_a   = a_neg ? (~operand_a_i + 1'b1) : operand_a_i;
    assign mag_b   = b_neg ? (~operand_b_i + 1'b1) : operand_b_i;
    assign b_zero  = (operand_b_i == '0);
    assign ovf_in  = signed_i & (operand_a_i == MinNeg) & (operand_b_i == '1);
    assign bypass  = ~data_ind_timing_i &
                     (op_i[1] ? (b_zero | ovf_in) : (EarlyTerm & b_zero));
    assign cnt_dec = cnt_q - CntW'(1);

    // One CALC step of the multiplier: add shifted copies of the multiplicand.
    always_comb begin
        mul_acc = acc_q;
        for (int i = 0; i < StepBits; i++) begin
            if (opb_q[i]) begin
                mul_acc = mul_acc + (mcand_q << i);
            end
        end
        mul_b_rest = opb_q >> StepBits;
        mul_early  = EarlyTerm & ~dit_q & ~op_q[1] & (mul_b_rest == '0);
    end

    // StepBits chained restoring-division steps; dq_q shifts the dividend out and the quotient in.
    always_comb begin
        div_r = {1'b0, rem_q};
        div_q = dq_q;
        for (int i = 0; i < StepBits; i++) begin
            div_r = {div_r[Width-1:0], div_q[Width-1]};
            div_q = {div_q[Width-2:0], 1'b0};
            if (div_r >= {1'b0, opb_q}) begin
                div_r    = div_r - {1'b0, opb_q};
                div_q[0] = 1'b1;
            end
        end
    end

    always_comb begin
        prod = neg_res_q ? (~acc_q + 1'b1) : acc_q;
        quo  = neg_res_q ? (~dq_q + 1'b1) : dq_q;
        remv = neg_a_q ? (~rem_q + 1'b1) : rem_q;
        case (op_q)
            OP_MUL:  fin_res = prod[Width-1:0];
            OP_MULH: fin_res = prod[2*Width-1:Width];
            OP_DIV:  fin_res = div_zero_q ? '1 : (ovf_q ? MinNeg : quo);
            default: fin_res = div_zero_q ? a_q : (ovf_q ? '0 : remv);
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        dit_d      = dit_q;
        neg_res_d  = neg_res_q;
        neg_a_d    = neg_a_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;
        a_d        = a_q;
        opb_d      = opb_q;
        mcand_d    = mcand_q;
        acc_d      = acc_q;
        dq_d       = dq_q;
        rem_d      = rem_q;
        result_d   = result_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d       = op_i;
                    dit_d      = data_ind_timing_i;
                    neg_res_d  = a_neg ^ b_neg;
                    neg_a_d    = a_neg;
                    div_zero_d = b_zero;
                    ovf_d      = ovf_in;
                    a_d        = operand_a_i;
                    opb_d      = mag_b;
                    mcand_d    = {{Width{1'b0}}, mag_a};
                    acc_d      = '0;
                    dq_d       = mag_a;
                    rem_d      = '0;
                    cnt_d      = CntInit;
                    state_d    = bypass ? FIN : CALC;
                end
            end
            CALC: begin
                if (kill_i) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_dec;
                    if (op_q[1]) begin
                        dq_d  = div_q;
                        rem_d = div_r[Width-1:0];
                    end else begin
                        acc_d   = mul_acc;
                        mcand_d = mcand_q << StepBits;
                        opb_d   = mul_b_rest;
                    end
                    if ((cnt_dec == '0) || mul_early) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                if (kill_i) begin
                    state_d = IDLE;
                end else begin
                    result_d = fin_res;
                    state_d  = DONE;
                end
            end
            default: begin
                if (kill_i || resp_ready_i) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            dit_q      <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_a_q    <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            a_q        <= '0;
            opb_q      <= '0;
            mcand_q    <= '0;
            acc_q      <= '0;
            dq_q       <= '0;
            rem_q      <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            dit_q      <= dit_d;
            neg_res_q  <= neg_res_d;
            neg_a_q    <= neg_a_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
            a_q        <= a_d;
            opb_q      <= opb_d;
            mcand_q    <= mcand_d;
            acc_q      <= acc_d;
            dq_q       <= dq_d;
            rem_q      <= rem_d;
            result_q   <= result_d;
        end
    end

endmodule

// File: tb/tb_ibex_ex_multdiv_iter.sv
// Table-driven bench for ibex_ex_multdiv_iter at StepBits 1, 2 and 4, plus directed
// sequences for kill, reset, backpressure and kill in the IDLE and DONE states.
module tb_ibex_ex_multdiv_iter;
    logic        clk;
    logic        rst;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [1:0]  op;
    logic        sgn;
    logic [31:0] opa, opb;
    logic        dit;
    logic [2:0]  kill;
    logic [2:0]  resp_valid;
    logic [2:0]  resp_ready;
    logic [31:0] result [3];
    logic [2:0]  busy;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0]  op;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic        dit;
        logic [31:0] exp;
        int          lat1;
        int          lat2;
        int          lat4;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    ibex_ex_multdiv_iter #(.Width(32), .StepBits(1), .EarlyTerm(1'b1)) u_sb1 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .op_i(op), .signed_i(sgn), .operand_a_i(opa), .operand_b_i(opb),
        .data_ind_timing_i(dit), .kill_i(kill[0]), .resp_valid_o(resp_valid[0]),
        .resp_ready_i(resp_ready[0]), .result_o(result[0]), .busy_o(busy[0])
    );
    ibex_ex_multdiv_iter #(.Width(32), .StepBits(2), .EarlyTerm(1'b1)) u_sb2 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .op_i(op), .signed_i(sgn), .operand_a_i(opa), .operand_b_i(opb),
        .data_ind_timing_i(dit), .kill_i(kill[1]), .resp_valid_o(resp_valid[1]),
        .resp_ready_i(resp_ready[1]), .result_o(result[1]), .busy_o(busy[1])
    );
    ibex_ex_multdiv_iter #(.Width(32), .StepBits(4), .EarlyTerm(1'b1)) u_sb4 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid[2]), .req_ready_o(req_ready[2]),
        .op_i(op), .signed_i(sgn), .operand_a_i(opa), .operand_b_i(opb),
        .data_ind_timing_i(dit), .kill_i(kill[2]), .resp_valid_o(resp_valid[2]),
        .resp_ready_i(resp_ready[2]), .result_o(result[2]), .busy_o(busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_req(input int idx, input logic [1:0] o, input logic s,
                             input logic [31:0] a, input logic [31:0] b, input logic d);
        op = o; sgn = s; opa = a; opb = b; dit = d;
        req_valid[idx] = 1'b1;
    endtask

    // Accept in the current cycle (cycle 0) and return the cycle resp_valid first rises.
    task automatic accept_and_wait(input int idx, input string name, output int cyc);
        #1;
        check({name, "_req_ready"}, 32'(req_ready[idx]), 32'd1);
        tick();
        req_valid[idx] = 1'b0;
        cyc = 1;
        while (resp_valid[idx] !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v, input int lat, input string name);
        int cyc;
        resp_ready[idx] = 1'b1;
        drive_req(idx, v.op, v.sgn, v.a, v.b, v.dit);
        accept_and_wait(idx, name, cyc);
        check({name, "_latency"}, 32'(cyc), 32'(lat));
        check({name, "_result"}, result[idx], v.exp);
        tick();
        check({name, "_idle_after"}, {30'd0, resp_valid[idx], req_ready[idx]}, 32'd1);
    endtask

    initial begin
        int cyc;
        int lat;
        vec_t v;

        // op, signed, a, b, dit, expected, latency for StepBits 1 / 2 / 4
        vecs[0]  = '{2'b00, 1'b0, 32'd7,        32'd6,        1'b1, 32'd42,       34, 18, 10};
        vecs[1]  = '{2'b00, 1'b0, 32'd7,        32'd6,        1'b0, 32'd42,        5,  4,  3};
        vecs[2]  = '{2'b01, 1'b1, 32'hFFFFFFFE, 32'd3,        1'b1, 32'hFFFFFFFF, 34, 18, 10};
        vecs[3]  = '{2'b01, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 34, 18, 10};
        vecs[4]  = '{2'b10, 1'b1, 32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFD, 34, 18, 10};
        vecs[5]  = '{2'b11, 1'b1, 32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFF, 34, 18, 10};
        vecs[6]  = '{2'b10, 1'b0, 32'd100,      32'd7,        1'b1, 32'd14,       34, 18, 10};
        vecs[7]  = '{2'b11, 1'b0, 32'd100,      32'd7,        1'b1, 32'd2,        34, 18, 10};
        vecs[8]  = '{2'b10, 1'b0, 32'd100,      32'd0,        1'b0, 32'hFFFFFFFF,  2,  2,  2};
        vecs[9]  = '{2'b10, 1'b0, 32'd100,      32'd0,        1'b1, 32'hFFFFFFFF, 34, 18, 10};
        vecs[10] = '{2'b10, 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 34, 18, 10};
        vecs[11] = '{2'b11, 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0,        34, 18, 10};
        vecs[12] = '{2'b10, 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h80000000,  2,  2,  2};
        vecs[13] = '{2'b11, 1'b0, 32'd100,      32'd0,        1'b0, 32'd100,       2,  2,  2};
        vecs[14] = '{2'b00, 1'b0, 32'd12345,    32'd0,        1'b0, 32'd0,         2,  2,  2};
        vecs[15] = '{2'b00, 1'b1, 32'hFFFFFFFD, 32'd5,        1'b1, 32'hFFFFFFF1, 34, 18, 10};
        vecs[16] = '{2'b10, 1'b1, 32'd7,        32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 34, 18, 10};
        vecs[17] = '{2'b01, 1'b1, 32'hFFFFFFFE, 32'd3,        1'b0, 32'hFFFFFFFF,  4,  3,  3};

        rst = 1'b1; req_valid = '0; kill = '0; resp_ready = '1;
        op = '0; sgn = 1'b0; opa = '0; opb = '0; dit = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_flags_%0d", k),
                  {28'd0, req_ready[k], resp_valid[k], busy[k], 1'b0}, 32'h8);
            check($sformatf("reset_result_%0d", k), result[k], 32'd0);
        end
        rst = 1'b0;
        tick();

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NV; i++) begin
                v = vecs[i];
                lat = (k == 0) ? v.lat1 : ((k == 1) ? v.lat2 : v.lat4);
                run_vec(k, v, lat, $sformatf("v%0d_inst%0d", i, k));
            end
        end

        // Kill a divide in its CALC phase at cycle 10, then start a multiply at cycle 11.
        drive_req(0, 2'b10, 1'b0, 32'd100, 32'd7, 1'b1);
        #1;
        tick();
        req_valid[0] = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        kill[0] = 1'b1;
        #1;
        check("kill_ready_low", 32'(req_ready[0]), 32'd0);
        tick();
        kill[0] = 1'b0;
        #1;
        check("kill_idle", {29'd0, busy[0], resp_valid[0], req_ready[0]}, 32'd1);
        v = '{2'b00, 1'b0, 32'd3, 32'd5, 1'b1, 32'd15, 34, 18, 10};
        run_vec(0, v, 34, "after_kill_mul");

        // Reset at cycle 10 of a divide.
        drive_req(0, 2'b10, 1'b0, 32'd100, 32'd7, 1'b1);
        #1;
        tick();
        req_valid[0] = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        rst = 1'b1;
        kill[0] = 1'b1;
        tick();
        check("rst_flags", {29'd0, busy[0], resp_valid[0], req_ready[0]}, 32'd0);
        kill[0] = 1'b0;
        #1;
        check("rst_ready", 32'(req_ready[0]), 32'd1);
        check("rst_result", result[0], 32'd0);
        rst = 1'b0;
        tick();

        // Kill while IDLE blocks acceptance.
        drive_req(0, 2'b00, 1'b0, 32'd3, 32'd5, 1'b1);
        kill[0] = 1'b1;
        #1;
        check("idle_kill_ready", 32'(req_ready[0]), 32'd0);
        tick();
        req_valid[0] = 1'b0;
        kill[0] = 1'b0;
        #1;
        check("idle_kill_not_busy", 32'(busy[0]), 32'd0);

        // Backpressure in DONE for five cycles.
        resp_ready[0] = 1'b0;
        drive_req(0, 2'b00, 1'b0, 32'd7, 32'd6, 1'b0);
        accept_and_wait(0, "bp", cyc);
        check("bp_latency", 32'(cyc), 32'd5);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp_hold_%0d", c),
                  {29'd0, resp_valid[0], req_ready[0], busy[0]}, 32'h5);
            check($sformatf("bp_result_%0d", c), result[0], 32'd42);
            tick();
        end
        resp_ready[0] = 1'b1;
        tick();
        check("bp_release", {29'd0, resp_valid[0], req_ready[0], busy[0]}, 32'h2);
        check("bp_result_kept", result[0], 32'd42);

        // Kill in DONE drops the pending response.
        resp_ready[0] = 1'b0;
        drive_req(0, 2'b00, 1'b0, 32'd3, 32'd5, 1'b0);
        accept_and_wait(0, "done_kill", cyc);
        check("done_kill_latency", 32'(cyc), 32'd5);
        kill[0] = 1'b1;
        tick();
        kill[0] = 1'b0;
        #1;
        check("done_kill_dropped", {29'd0, resp_valid[0], req_ready[0], busy[0]}, 32'h2);
        resp_ready[0] = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ibex_ex_multdiv_iter.md
Name: ibex_ex_multdiv_iter

Overview:
Parametrised iterative multiply/divide unit for the execution stage. It is the successor to the fixed 32-bit multdiv path, generalised in operand width and in bits retired per cycle. Unlike that path, it adds a valid/ready request/response handshake, optional early termination, and a kill input. It sits beside the ALU in the EX block and owns its own intermediate registers, so no imd_val muxing is needed.

Parameters:
Width, 32, operand/result width in bits; must be even and at least 8.
StepBits, 1, multiplier/quotient bits retired per CALC cycle; one of 1, 2, 4; must divide Width.
EarlyTerm, 1, enables skipping of CALC cycles when data_ind_timing_i is low at accept.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
req_valid_i  in  1  request valid
req_ready_o  out  1  unit can accept a request
op_i  in  2  00 MUL (low half), 01 MULH (high half), 10 DIV, 11 REM
signed_i  in  1  both operands are two's complement
operand_a_i  in  Width  multiplicand / dividend
operand_b_i  in  Width  multiplier / divisor
data_ind_timing_i  in  1  force fixed latency; sampled at accept
kill_i  in  1  abort current operation
resp_valid_o  out  1  result valid
resp_ready_i  in  1  consumer accepts result
result_o  out  Width  result
busy_o  out  1  state != IDLE

Behaviour:
- States: IDLE, CALC, FIN, DONE. N = Width/StepBits.
- Reset (rst_i high at a clock edge, from any state): next state IDLE.
  - Reset values: req_ready_o=1, resp_valid_o=0, result_o=0, busy_o=0.
  - Internal counter and accumulators are cleared.
- req_ready_o = (state==IDLE) & ~kill_i.
- Accept occurs on req_valid_i & req_ready_o.
  - Operands, op, sign and timing mode are latched.
  - Magnitudes are computed if signed_i=1; the result sign is recorded.
  - Counter is set to N.
- Accept transition, normally: IDLE->CALC.
- Accept transition directly to FIN (bypasses CALC) when data_ind_timing_i=0 and any of:
  - DIV/REM with divisor 0;
  - DIV/REM with signed overflow (a = most-negative value, b = -1);
  - EarlyTerm=1, MUL/MULH, and |b| = 0.
- CALC, multiply: shift-add of StepBits bits of |b| per cycle into a 2*Width accumulator.
- CALC, divide: StepBits chained restoring-division steps per cycle into quotient and remainder registers.
- CALC exit: leave for FIN when the counter reaches 0.
- CALC early exit: with EarlyTerm=1, timing flag 0 and MUL/MULH, also leave for FIN once the remaining unconsumed multiplier bits are all 0.
- FIN lasts one cycle.
  - Applies sign correction: product negated if operand signs differ; quotient negated if signs differ; remainder takes the dividend sign.
  - Loads result_o, then moves to DONE.
- DONE: resp_valid_o=1. result_o is held stable until resp_ready_i=1, then next state is IDLE.
  - No new accept is possible in the handshake cycle.
- Special results (RISC-V semantics), identical with data_ind_timing_i=1, but computed after the full N CALC cycles:
  - divide by zero: DIV = all-ones, REM = dividend;
  - signed overflow: DIV = most-negative value, REM = 0.
- Latency from the accept cycle (cycle 0):
  - full path: resp_valid_o first high at cycle N+2;
  - bypass: resp_valid_o high at cycle 2.
- kill_i in any non-IDLE state: next state IDLE, resp_valid_o=0 the next cycle, result discarded.
  - kill_i in DONE drops the pending response.
- kill_i in IDLE blocks acceptance that cycle.
- kill_i together with rst_i: reset dominates (same outcome).
- result_o keeps its last value in IDLE; it is not cleared except by reset.

Test Plan:
- Width=32, StepBits=1, dit=1, MUL 7*6 accepted at cycle 0 -> resp_valid_o at cycle 34, result 42. Same with dit=0 -> resp_valid_o at cycle 5 (3 CALC cycles), result 42.
- MULH signed 0xFFFFFFFE * 3 -> 0xFFFFFFFF. MULH unsigned 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV signed -7/2 -> 0xFFFFFFFD; REM signed -7/2 -> 0xFFFFFFFF. DIV unsigned 100/7 -> 14; REM -> 2.
- DIV 100/0 with dit=0 -> 0xFFFFFFFF at cycle 2. With dit=1 -> same value at cycle 34. Signed 0x80000000/0xFFFFFFFF -> DIV 0x80000000, REM 0.
- kill_i at cycle 10 of a DIV -> IDLE at cycle 11, req_ready_o=1, no resp_valid_o. A new MUL 3*5 accepted at cycle 11 -> result 15. Repeat with rst_i at cycle 10 -> all outputs at reset values at cycle 11.
- Backpressure: resp_ready_i held 0 for 5 cycles in DONE -> resp_valid_o and result_o stable, req_ready_o=0. Then resp_ready_i=1 -> IDLE next cycle. Rerun the first, third and fourth scenarios with StepBits=2 and 4 -> full-path latency 18 and 10 cycles, same values.
